voice_scheduler: RTL and testbench

//  Time-multiplexes one shared sample-memory read port among NVOICE drum voices.
//  Per voice: trigger edge detect, playback pointer, end-of-sample retire.

---
 rtl/drumseq_pkg.sv | 18 +
 rtl/tick_gen.sv | 32 +++
 rtl/voice_scheduler.sv | 153 +++++++++++++++
 tb/tb_voice_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/drumseq_pkg.sv
// Shared types and helpers for the drum voice scheduler.
// Scheduler FSM states, voice limit and region address helper.
package drumseq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        OUT
    } sched_state_t;

    localparam int NVOICE_MAX = 4;

    function automatic logic [31:0] region_base(input int v, input int sh);
        return 32'(v) << sh;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-tick generator: free-running counter 0..div-1,
// one-clock tick pulse registered at each wrap.
module tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;
    logic        wrap;

    always_comb begin
        wrap   = (cnt_q == div - 16'd1);
        cnt_d  = wrap ? 16'd0 : cnt_q + 16'd1;
        tick_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one sample-memory read port across drum voices
// and sums one byte per active voice into an 8-bit mix each tick.
module voice_scheduler
    import drumseq_pkg::*;
#(
    parameter int NVOICE     = 4,
    parameter int ADDR_W     = 14,
    parameter int REGION_SH  = 12,
    parameter int SAMPLE_LEN = 4000,
    parameter int TICK_DIV   = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NVOICE-1:0] trig,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mix,
    output logic              mix_valid,
    output logic [NVOICE-1:0] active,
    output logic              overrun
);

    localparam int SW = $clog2(NVOICE);
    localparam int AW = 8 + $clog2(NVOICE_MAX);
    localparam int PW = REGION_SH;

    sched_state_t      state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     ptr_q [NVOICE];
    logic [PW-1:0]     ptr_d [NVOICE];
    logic [NVOICE-1:0] active_q, active_d;
    logic [NVOICE-1:0] pending_q, pending_d;
    logic [NVOICE-1:0] trig_q;
    logic [NVOICE-1:0] rise;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mix_q, mix_d;
    logic              mix_valid_q, mix_valid_d;
    logic              overrun_q, overrun_d;
    logic              tick;

    tick_gen u_tick (
        .clk  (clk),
        .rst  (rst),
        .div  (16'(TICK_DIV)),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        active_d    = active_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;
        for (int v = 0; v < NVOICE; v++) ptr_d[v] = ptr_q[v];
        rise      = trig & ~trig_q;
        pending_d = pending_q | rise;

        if (tick && state_q != IDLE) overrun_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ISSUE;
                    slot_d  = '0;
                    acc_d   = '0;
                    for (int v = 0; v < NVOICE; v++) begin
                        if (pending_q[v]) begin
                            active_d[v] = 1'b1;
                            ptr_d[v]    = '0;
                        end
                    end
                    pending_d = rise;
                    if (!enable) begin
                        active_d  = '0;
                        pending_d = '0;
                    end
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                // active cannot change between ISSUE and CAPT, so it marks a read
                if (active_q[slot_q]) begin
                    acc_d = acc_q + AW'(mem_rdata);
                    if (ptr_q[slot_q] == PW'(SAMPLE_LEN - 1))
                        active_d[slot_q] = 1'b0;
                    else
                        ptr_d[slot_q] = ptr_q[slot_q] + 1'b1;
                end
                if (slot_q == SW'(NVOICE - 1)) begin
                    state_d     = OUT;
                    mix_d       = acc_d[AW-1:AW-8];
                    mix_valid_d = 1'b1;
                end else begin
                    state_d = ISSUE;
                    slot_d  = slot_q + 1'b1;
                end
            end
            OUT: state_d = IDLE;
        endcase

        if (state_d == ISSUE && active_d[slot_d]) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = ADDR_W'(region_base(int'(slot_d), REGION_SH))
                       + ADDR_W'(ptr_d[slot_d]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            acc_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            trig_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int v = 0; v < NVOICE; v++) ptr_q[v] <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            trig_q      <= trig;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
            for (int v = 0; v < NVOICE; v++) ptr_q[v] <= ptr_d[v];
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mix       = mix_q;
    assign mix_valid = mix_valid_q;
    assign active    = active_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a fast tick (TICK_DIV=10)
// and a one-cycle-latency sample memory model.
module tb_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  trig;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mix;
    logic        mix_valid;
    logic [3:0]  active;
    logic        overrun;

    logic [7:0]  mem [0:16383];
    int          cyc = 0;
    int          nerr = 0;
    int          nchk = 0;

    logic [7:0]  fr_mix;
    int          fr_nrd;
    logic [13:0] fr_addr [4];
    int          fr_cyc;

    voice_scheduler #(
        .NVOICE     (4),
        .ADDR_W     (14),
        .REGION_SH  (12),
        .SAMPLE_LEN (4000),
        .TICK_DIV   (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .trig      (trig),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mix       (mix),
        .mix_valid (mix_valid),
        .active    (active),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [7:0] val);
        for (int a = lo; a < hi; a++) mem[a] = val;
    endtask

    // Run until the next mix_valid, logging read strobes on the way.
    task automatic wait_frame();
        bit got = 0;
        fr_nrd = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (mem_rd) begin
                if (fr_nrd < 4) fr_addr[fr_nrd] = mem_addr;
                fr_nrd++;
            end
            if (mix_valid) begin
                got    = 1;
                fr_mix = mix;
                fr_cyc = cyc;
            end
        end
        if (!got) begin
            nchk++;
            nerr++;
            $error("FAIL frame_timeout: observed no mix_valid expected one");
        end
    endtask

    initial begin
        int n;
        int cnt;
        int prev;
        rst    = 1'b0;
        enable = 1'b1;
        trig   = 4'b0100;
        fill(0, 16384, 8'h00);

        // start a frame with voice 2 playing, then reset mid-frame
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (16) @(posedge clk); #1;
        rst  = 1'b0;
        trig = 4'b0000;
        repeat (3) @(posedge clk); #1;
        check("rst_mix", 32'(mix), 32'h0);
        check("rst_mix_valid", 32'(mix_valid), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        rst = 1'b1;
        n   = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (mix_valid) break;
        end
        check("first_valid_clk", 32'(n), 32'd19);
        check("idle_mix", 32'(mix), 32'h0);

        // single voice 1
        fill(16'h1000, 16'h2000, 8'h40);
        trig = 4'b0010;
        wait_frame();
        check("v1_nrd", 32'(fr_nrd), 32'd1);
        check("v1_addr0", 32'(fr_addr[0]), 32'h1000);
        check("v1_mix", 32'(fr_mix), 32'h10);
        check("v1_active", 32'(active), 32'h2);
        wait_frame();
        check("v1_addr1", 32'(fr_addr[0]), 32'h1001);
        cnt = 2;
        for (int i = 0; i < 4100; i++) begin
            wait_frame();
            if (fr_mix != 8'h10) break;
            cnt++;
        end
        check("v1_frames", 32'(cnt), 32'd4000);
        check("v1_retired_mix", 32'(fr_mix), 32'h0);
        check("v1_retired_active", 32'(active), 32'h0);

        // full mix
        trig = 4'b0000;
        fill(0, 16384, 8'hFF);
        wait_frame();
        trig = 4'b1111;
        wait_frame();
        check("full_nrd", 32'(fr_nrd), 32'd4);
        check("full_addr0", 32'(fr_addr[0]), 32'h0000);
        check("full_addr1", 32'(fr_addr[1]), 32'h1000);
        check("full_addr2", 32'(fr_addr[2]), 32'h2000);
        check("full_addr3", 32'(fr_addr[3]), 32'h3000);
        check("full_mix", 32'(fr_mix), 32'hFF);

        // retrigger voice 0 once it has reached ptr 100
        trig = 4'b1110;
        repeat (99) wait_frame();
        check("rt_addr_ptr99", 32'(fr_addr[0]), 32'h0063);
        trig = 4'b1111;
        wait_frame();
        check("rt_restart", 32'(fr_addr[0]), 32'h0000);
        check("rt_other_voice", 32'(fr_addr[1]), 32'h1064);
        repeat (3) wait_frame();
        check("rt_held_no_restart", 32'(fr_addr[0]), 32'h0003);

        // forced tick during ISSUE of slot 1
        check("ovr_before", 32'(overrun), 32'h0);
        prev = fr_cyc;
        repeat (4) @(posedge clk); #1;
        force dut.tick = 1'b1;
        @(posedge clk); #1;
        release dut.tick;
        wait_frame();
        check("ovr_spacing1", 32'(fr_cyc - prev), 32'd10);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_mix", 32'(fr_mix), 32'hFF);
        prev = fr_cyc;
        wait_frame();
        check("ovr_spacing2", 32'(fr_cyc - prev), 32'd10);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // mute: retire everything, start voices 0 and 2, drop enable mid-frame
        enable = 1'b0;
        trig   = 4'b0000;
        wait_frame();
        check("mute_clear_active", 32'(active), 32'h0);
        enable = 1'b1;
        trig   = 4'b0101;
        wait_frame();
        check("mute_two_nrd", 32'(fr_nrd), 32'd2);
        check("mute_two_mix", 32'(fr_mix), 32'h7F);
        check("mute_two_active", 32'(active), 32'h5);
        repeat (3) @(posedge clk); #1;
        enable = 1'b0;
        wait_frame();
        check("mute_cur_frame_mix", 32'(fr_mix), 32'h7F);
        wait_frame();
        check("mute_next_mix", 32'(fr_mix), 32'h0);
        check("mute_next_nrd", 32'(fr_nrd), 32'd0);
        check("mute_next_active", 32'(active), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
